// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: status bus encodings and the burst capture FSM states.
package iagc_pkg;

  localparam int IAGC_STATUS_SIZE = 4;

  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_RESET = 4'b0000;
  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT  = 4'b0001;
  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_IDLE  = 4'b0010;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } burst_state_e;

endpackage

// File: rtl/sample_trigger_channel.sv
// One capture engine: gate edge detect, burst FSM with delay/sample counters,
// and registered valid/done strobes.
module sample_trigger_channel
  import iagc_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_mode,
  input  logic                   i_adc_data_valid,
  input  logic                   i_gate,
  input  logic [COUNT_WIDTH-1:0] i_delay,
  input  logic [COUNT_WIDTH-1:0] i_num_samples,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  burst_state_e           state_q, state_d;
  logic                   gate_q, rise;
  logic [COUNT_WIDTH-1:0] dly_q, dly_d, smp_q, smp_d;
  logic                   valid_d, done_d;

  assign rise = i_gate & ~gate_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_WAIT;
      gate_q  <= 1'b0;
      dly_q   <= '0;
      smp_q   <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= i_gate;
      dly_q   <= dly_d;
      smp_q   <= smp_d;
      o_valid <= valid_d;
      o_done  <= done_d;
    end
  end

  // Mode is only consulted in WAIT, so a burst in flight always finishes.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    smp_d   = smp_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (!i_run) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (!i_mode) begin
            valid_d = i_gate & i_adc_data_valid;
          end else if (rise) begin
            dly_d = i_delay;
            smp_d = i_num_samples;
            if (i_num_samples == '0) begin
              state_d = ST_HOLDOFF;
              done_d  = 1'b1;
            end else if (i_delay == '0) begin
              state_d = ST_CAPTURE;
            end else begin
              state_d = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (i_adc_data_valid) begin
            dly_d = dly_q - ONE;
            if (dly_q == ONE) state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (i_adc_data_valid) begin
            valid_d = 1'b1;
            smp_d   = smp_q - ONE;
            if (smp_q == ONE) begin
              state_d = ST_HOLDOFF;
              done_d  = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (!i_gate) state_d = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    o_busy = (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
  end

endmodule

// File: rtl/sample_trigger_mc.sv
// Multi-channel sample trigger: one capture engine per gate, all sharing the
// ADC strobe, mode, burst config and the IAGC run qualifier.
module sample_trigger_mc #(
  parameter int N_CHANNELS       = 4,
  parameter int IAGC_STATUS_SIZE = iagc_pkg::IAGC_STATUS_SIZE,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic                        i_adc_data_valid,
  input  logic [N_CHANNELS-1:0]       i_gate,
  input  logic                        i_mode,
  input  logic [COUNT_WIDTH-1:0]      i_delay,
  input  logic [COUNT_WIDTH-1:0]      i_num_samples,
  output logic [N_CHANNELS-1:0]       o_valid,
  output logic [N_CHANNELS-1:0]       o_busy,
  output logic [N_CHANNELS-1:0]       o_done
);

  logic run;

  assign run = (i_iagc_status == IAGC_STATUS_SIZE'(iagc_pkg::IAGC_STATUS_IDLE));

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    sample_trigger_channel #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_ch (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_run            (run),
      .i_mode           (i_mode),
      .i_adc_data_valid (i_adc_data_valid),
      .i_gate           (i_gate[c]),
      .i_delay          (i_delay),
      .i_num_samples    (i_num_samples),
      .o_valid          (o_valid[c]),
      .o_busy           (o_busy[c]),
      .o_done           (o_done[c])
    );
  end

endmodule

// File: tb/tb_sample_trigger_mc.sv
// Randomized and directed checks of sample_trigger_mc against a skip/take
// behavioural model of each capture engine.
module tb_sample_trigger_mc;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  status = 4'b0000;
  logic        adc = 1'b0;
  logic [N-1:0] gate = '0;
  logic        mode = 1'b0;
  logic [15:0] delay = '0;
  logic [15:0] nsamp = '0;
  logic [N-1:0] o_valid, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  sample_trigger_mc dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_iagc_status    (status),
    .i_adc_data_valid (adc),
    .i_gate           (gate),
    .i_mode           (mode),
    .i_delay          (delay),
    .i_num_samples    (nsamp),
    .o_valid          (o_valid),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  // Model: an armed burst has 'skip' strobes to ignore then 'take' to pass.
  int       skip [N];
  int       take [N];
  bit       act  [N];
  bit       hold [N];
  bit [N-1:0] gq_m = '0;
  bit [N-1:0] exp_valid = '0, exp_busy = '0, exp_done = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        skip[c] = 0; take[c] = 0; act[c] = 0; hold[c] = 0;
      end
      gq_m = '0; exp_valid = '0; exp_busy = '0; exp_done = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        bit ev, ed;
        ev = 0; ed = 0;
        if (status != 4'b0010) begin
          act[c] = 0; hold[c] = 0;
        end else if (act[c]) begin
          if (adc) begin
            if (skip[c] > 0) skip[c]--;
            else begin
              ev = 1; take[c]--;
              if (take[c] == 0) begin ed = 1; act[c] = 0; hold[c] = 1; end
            end
          end
        end else if (hold[c]) begin
          if (!gate[c]) hold[c] = 0;
        end else if (!mode) begin
          ev = gate[c] & adc;
        end else if (gate[c] && !gq_m[c]) begin
          if (nsamp == 0) begin ed = 1; hold[c] = 1; end
          else begin act[c] = 1; skip[c] = int'(delay); take[c] = int'(nsamp); end
        end
        gq_m[c] = gate[c];
        exp_valid[c] = ev; exp_done[c] = ed; exp_busy[c] = act[c];
      end
    end
  end

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act_v, exp_v);
    end
  endtask

  int cnt_v [N];
  int cnt_d [N];
  int base_v [N];
  int base_d [N];
  initial for (int c = 0; c < N; c++) begin cnt_v[c] = 0; cnt_d[c] = 0; end

  always @(negedge clk) begin
    chk("o_valid", int'(o_valid), int'(exp_valid));
    chk("o_busy",  int'(o_busy),  int'(exp_busy));
    chk("o_done",  int'(o_done),  int'(exp_done));
    for (int c = 0; c < N; c++) begin
      cnt_v[c] += int'(o_valid[c]);
      cnt_d[c] += int'(o_done[c]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic snap();
    for (int c = 0; c < N; c++) begin base_v[c] = cnt_v[c]; base_d[c] = cnt_d[c]; end
  endtask

  function automatic int dv(input int c); return cnt_v[c] - base_v[c]; endfunction
  function automatic int dd(input int c); return cnt_d[c] - base_d[c]; endfunction

  initial begin
    #1 rst = 1'b1;
    step(3);
    // Reset then non-IDLE statuses: nothing may come out
    rst = 1'b0; adc = 1'b1; status = 4'b0000; snap();
    for (int i = 0; i < 12; i++) begin
      if (i == 6) status = 4'b0001;
      gate = 4'(i * 5);
      mode = i[2];
      step();
    end
    chk("nonidle_valid_count", dv(0) + dv(1) + dv(2) + dv(3), 0);
    chk("nonidle_done_count",  dd(0) + dd(1) + dd(2) + dd(3), 0);

    // Level mode: gate[0] high for 10 cycles
    gate = '0; mode = 1'b0; status = 4'b0010; step(2); snap();
    gate = 4'b0001; step(10);
    gate = '0; step(3);
    chk("level_valid0_count", dv(0), 10);
    chk("level_others_count", dv(1) + dv(2) + dv(3), 0);

    // Burst: delay 2, 3 samples, strobe every 4th cycle on gate[1]
    mode = 1'b1; delay = 16'd2; nsamp = 16'd3; adc = 1'b0; snap();
    gate = 4'b0010;
    for (int i = 0; i < 40; i++) begin adc = (i % 4 == 3); step(); end
    chk("burst_valid1_count", dv(1), 3);
    chk("burst_done1_count",  dd(1), 1);
    gate = '0; adc = 1'b0; step(2);

    // Zero samples: done only
    nsamp = '0; snap(); gate = 4'b0100; step(4);
    chk("zero_done2_count",  dd(2), 1);
    chk("zero_valid2_count", dv(2), 0);
    gate = '0; step(2);

    // Zero delay, continuous strobes
    delay = '0; nsamp = 16'd2; adc = 1'b1; snap(); gate = 4'b1000; step(6);
    chk("nodelay_valid3_count", dv(3), 2);
    gate = '0; step(2);

    // Held gate, staggered rise, early gate drop
    delay = 16'd1; nsamp = 16'd4; snap();
    gate = 4'b0101;
    for (int i = 0; i < 30; i++) begin
      adc = i[0];
      if (i == 2) gate = 4'b1100;
      step();
    end
    chk("held_valid2_count", dv(2), 4);
    chk("indep_valid3_count", dv(3), 4);
    chk("drop_valid0_count", dv(0), 4);
    gate = 4'b1000; step(); gate = 4'b1100; snap();
    for (int i = 0; i < 20; i++) begin adc = i[0]; step(); end
    chk("rearm_valid2_count", dv(2), 4);
    gate = '0; step(2);

    // Leave IDLE mid-capture, then return with gates still high
    delay = '0; nsamp = 16'd50; adc = 1'b1; gate = 4'hF; step(5);
    status = 4'b0001; step(); snap(); step(4);
    chk("abort_done_count", dd(0) + dd(1) + dd(2) + dd(3), 0);
    chk("abort_valid_count", dv(0) + dv(1) + dv(2) + dv(3), 0);
    status = 4'b0010; snap(); step(10);
    chk("noretrig_valid_count", dv(0) + dv(1) + dv(2) + dv(3), 0);

    // Async reset mid-burst
    gate = '0; step(2); delay = 16'd1; nsamp = 16'd20; gate = 4'hF; step(4);
    rst = 1'b1; #1;
    chk("areset_valid", int'(o_valid), 0);
    chk("areset_busy",  int'(o_busy), 0);
    chk("areset_done",  int'(o_done), 0);
    step(2); rst = 1'b0; step(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      status = ($urandom % 16 == 0) ? 4'($urandom % 4) : 4'b0010;
      for (int c = 0; c < N; c++) if ($urandom % 8 == 0) gate[c] = ~gate[c];
      if ($urandom % 64 == 0) mode = ~mode;
      adc   = ($urandom % 3 != 0);
      delay = 16'($urandom % 4);
      nsamp = 16'($urandom % 5);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
